mem_access_arbiter: RTL and testbench

- Shares the single calculator data memory between two command requesters: port 0 is the host command flow and port 1 is the secondary/self-test flow.
- Arbitrates round-robin and latches the winner's address, data and direction.
- Drives the memory strobe, then waits a fixed memory latency and returns read data with a one-cycle Done pulse.
- Sits between the control FSMs and the memory array; accepts new requests only while the unlock decoder reports Active.

---
 rtl/mem_access_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - round-robin two-port arbiter for the shared data memory
module mem_access_arbiter #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Active,
  input  logic              Req0,
  input  logic              RW0,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [DATA_W-1:0] WData0,
  input  logic              Req1,
  input  logic              RW1,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData1,
  output logic              Grant0,
  output logic              Grant1,
  output logic              Done0,
  output logic              Done1,
  output logic [DATA_W-1:0] RData,
  output logic              Busy,
  output logic              AccessMem,
  output logic              RWMem,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_t;

  // Counter preload: WAIT lasts MEM_LAT cycles, the last one samples MemRData.
  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              win_q, win_d;
  logic              last_q, last_d;
  logic              grant0_q, grant0_d;
  logic              grant1_q, grant1_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              access_q, access_d;
  logic              rwmem_q, rwmem_d;
  logic [ADDR_W-1:0] memaddr_q, memaddr_d;
  logic [DATA_W-1:0] memwdata_q, memwdata_d;
  logic              pick;

  // Next-state and next-output computation; every output is the registered image of its _d.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    win_d      = win_q;
    last_d     = last_q;
    rdata_d    = rdata_q;
    rwmem_d    = rwmem_q;
    memaddr_d  = memaddr_q;
    memwdata_d = memwdata_q;
    grant0_d   = 1'b0;
    grant1_d   = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    access_d   = 1'b0;
    busy_d     = 1'b0;
    // On a tie the port that was not served last wins; otherwise the lone requester.
    pick       = (Req0 && Req1) ? ~last_q : Req1;

    case (state_q)
      S_IDLE: begin
        if (Active && (Req0 || Req1)) begin
          win_d      = pick;
          rwmem_d    = pick ? RW1 : RW0;
          memaddr_d  = pick ? Addr1 : Addr0;
          memwdata_d = pick ? WData1 : WData0;
          grant0_d   = ~pick;
          grant1_d   = pick;
          access_d   = 1'b1;
          busy_d     = 1'b1;
          state_d    = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cnt_d   = LAT_LOAD;
        busy_d  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        busy_d = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!rwmem_q) begin
            rdata_d = MemRData;
          end
          done0_d = ~win_q;
          done1_d = win_q;
          busy_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        last_d  = win_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset overrides any access in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      win_q      <= 1'b0;
      last_q     <= 1'b1;
      grant0_q   <= 1'b0;
      grant1_q   <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      access_q   <= 1'b0;
      rwmem_q    <= 1'b0;
      memaddr_q  <= '0;
      memwdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      win_q      <= win_d;
      last_q     <= last_d;
      grant0_q   <= grant0_d;
      grant1_q   <= grant1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      access_q   <= access_d;
      rwmem_q    <= rwmem_d;
      memaddr_q  <= memaddr_d;
      memwdata_q <= memwdata_d;
    end
  end

  assign Grant0    = grant0_q;
  assign Grant1    = grant1_q;
  assign Done0     = done0_q;
  assign Done1     = done1_q;
  assign RData     = rdata_q;
  assign Busy      = busy_q;
  assign AccessMem = access_q;
  assign RWMem     = rwmem_q;
  assign MemAddr   = memaddr_q;
  assign MemWData  = memwdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - directed self-checking bench for mem_access_arbiter
module tb_mem_access_arbiter;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Active = 1'b0;
  logic       Req0 = 1'b0, RW0 = 1'b0, Req1 = 1'b0, RW1 = 1'b0;
  logic [3:0] Addr0 = '0, Addr1 = '0;
  logic [7:0] WData0 = '0, WData1 = '0;

  logic       grant0, grant1, done0, done1, busy, access_mem, rw_mem;
  logic [7:0] rdata, mem_wdata, mem_rdata;
  logic [3:0] mem_addr;

  logic       g0_l [2], g1_l [2], d0_l [2], d1_l [2], busy_l [2], acc_l [2], rw_l [2];
  logic [7:0] rdata_l [2], wdata_l [2];
  logic [3:0] addr_l [2];

  logic [7:0] mem [16];
  int         cyc_n = 0;
  logic [7:0] cyc_rdata;
  int         tests_run = 0;
  int         tests_failed = 0;

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc_n <= cyc_n + 1;
  assign cyc_rdata = cyc_n[7:0];

  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else if (access_mem && rw_mem) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  mem_access_arbiter #(.ADDR_W(4), .DATA_W(8), .MEM_LAT(2)) dut (
    .Clk(Clk), .Reset(Reset), .Active(Active),
    .Req0(Req0), .RW0(RW0), .Addr0(Addr0), .WData0(WData0),
    .Req1(Req1), .RW1(RW1), .Addr1(Addr1), .WData1(WData1),
    .Grant0(grant0), .Grant1(grant1), .Done0(done0), .Done1(done1),
    .RData(rdata), .Busy(busy), .AccessMem(access_mem), .RWMem(rw_mem),
    .MemAddr(mem_addr), .MemWData(mem_wdata), .MemRData(mem_rdata)
  );

  mem_access_arbiter #(.ADDR_W(4), .DATA_W(8), .MEM_LAT(1)) dut_l1 (
    .Clk(Clk), .Reset(Reset), .Active(Active),
    .Req0(Req0), .RW0(RW0), .Addr0(Addr0), .WData0(WData0),
    .Req1(Req1), .RW1(RW1), .Addr1(Addr1), .WData1(WData1),
    .Grant0(g0_l[0]), .Grant1(g1_l[0]), .Done0(d0_l[0]), .Done1(d1_l[0]),
    .RData(rdata_l[0]), .Busy(busy_l[0]), .AccessMem(acc_l[0]), .RWMem(rw_l[0]),
    .MemAddr(addr_l[0]), .MemWData(wdata_l[0]), .MemRData(cyc_rdata)
  );

  mem_access_arbiter #(.ADDR_W(4), .DATA_W(8), .MEM_LAT(15)) dut_l15 (
    .Clk(Clk), .Reset(Reset), .Active(Active),
    .Req0(Req0), .RW0(RW0), .Addr0(Addr0), .WData0(WData0),
    .Req1(Req1), .RW1(RW1), .Addr1(Addr1), .WData1(WData1),
    .Grant0(g0_l[1]), .Grant1(g1_l[1]), .Done0(d0_l[1]), .Done1(d1_l[1]),
    .RData(rdata_l[1]), .Busy(busy_l[1]), .AccessMem(acc_l[1]), .RWMem(rw_l[1]),
    .MemAddr(addr_l[1]), .MemWData(wdata_l[1]), .MemRData(cyc_rdata)
  );

  task automatic do_reset();
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [29:0] all_out;
    Active = 1'b0; Req0 = 1'b0; Req1 = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    all_out = {grant0, grant1, done0, done1, busy, access_mem, rw_mem, rdata, mem_addr, mem_wdata};
    tests_run++;
    if (all_out !== 30'd0) begin tests_failed++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    for (int k = 0; k < 2; k++) begin
      all_out = {g0_l[k], g1_l[k], d0_l[k], d1_l[k], busy_l[k], acc_l[k], rw_l[k], rdata_l[k], addr_l[k], wdata_l[k]};
      tests_run++;
      if (all_out !== 30'd0) begin tests_failed++; $display("FAIL reset_outputs_lat%0d: got %h want 0", k, all_out); end
    end
    Reset = 1'b0;
  endtask

  task automatic test_write();
    Active = 1'b1; Req0 = 1'b1; RW0 = 1'b1; Addr0 = 4'h3; WData0 = 8'hA5;
    @(negedge Clk);
    tests_run++;
    if ({grant0, grant1, access_mem, rw_mem, busy} !== 5'b10111) begin
      tests_failed++; $display("FAIL write_grant: got %b want 10111", {grant0, grant1, access_mem, rw_mem, busy});
    end
    tests_run++;
    if ({mem_addr, mem_wdata} !== 12'h3A5) begin tests_failed++; $display("FAIL write_latch: got %h want 3a5", {mem_addr, mem_wdata}); end
    Req0 = 1'b0; Addr0 = 4'hC; WData0 = 8'h5A;
    @(negedge Clk);
    tests_run++;
    if ({access_mem, grant0, done0, mem_addr} !== 7'h03) begin
      tests_failed++; $display("FAIL write_wait1: got %h want 03", {access_mem, grant0, done0, mem_addr});
    end
    @(negedge Clk);
    tests_run++;
    if (done0 !== 1'b0) begin tests_failed++; $display("FAIL write_early_done: got %b want 0", done0); end
    @(negedge Clk);
    tests_run++;
    if ({done0, done1, busy, rdata} !== 11'b101_00000000) begin
      tests_failed++; $display("FAIL write_done: got %b want 10100000000", {done0, done1, busy, rdata});
    end
    @(negedge Clk);
    tests_run++;
    if ({done0, busy} !== 2'b00) begin tests_failed++; $display("FAIL write_idle: got %b want 00", {done0, busy}); end
  endtask

  task automatic test_read();
    Req1 = 1'b1; RW1 = 1'b0; Addr1 = 4'h3;
    @(negedge Clk);
    tests_run++;
    if ({grant0, grant1, access_mem, rw_mem} !== 4'b0110) begin
      tests_failed++; $display("FAIL read_grant: got %b want 0110", {grant0, grant1, access_mem, rw_mem});
    end
    Req1 = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    tests_run++;
    if (done1 !== 1'b0) begin tests_failed++; $display("FAIL read_early_done: got %b want 0", done1); end
    @(negedge Clk);
    tests_run++;
    if ({done1, done0, rdata} !== 10'b10_10100101) begin
      tests_failed++; $display("FAIL read_done: got %b want 1010100101", {done1, done0, rdata});
    end
    @(negedge Clk);
    tests_run++;
    if ({done1, rdata} !== 9'b0_10100101) begin tests_failed++; $display("FAIL read_hold: got %b want 010100101", {done1, rdata}); end
  endtask

  task automatic test_round_robin();
    int n_grant = 0;
    int conflicts = 0;
    int g_cyc [4];
    logic g_port [4];
    Active = 1'b1; Req0 = 1'b1; RW0 = 1'b0; Addr0 = 4'h1; Req1 = 1'b1; RW1 = 1'b0; Addr1 = 4'h2;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if ((grant0 && grant1) || (done0 && done1)) conflicts++;
      if ((grant0 || grant1) && n_grant < 4) begin
        g_cyc[n_grant] = i; g_port[n_grant] = grant1; n_grant++;
      end
    end
    Req0 = 1'b0; Req1 = 1'b0;
    tests_run++;
    if (n_grant !== 4) begin tests_failed++; $display("FAIL rr_count: got %0d want 4", n_grant); end
    tests_run++;
    if (conflicts !== 0) begin tests_failed++; $display("FAIL rr_conflict: got %0d want 0", conflicts); end
    for (int j = 0; j < 4; j++) begin
      if (j < n_grant) begin
        tests_run++;
        if (g_port[j] !== j[0] || g_cyc[j] !== 5 * j) begin
          tests_failed++; $display("FAIL rr_grant%0d: got port %0d cycle %0d want port %0d cycle %0d", j, g_port[j], g_cyc[j], j[0], 5 * j);
        end
      end
    end
  endtask

  task automatic test_active();
    int bad = 0;
    Active = 1'b0; Req0 = 1'b1; RW0 = 1'b0; Addr0 = 4'h1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (grant0 || grant1 || busy) bad++;
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL inactive_grant: got %0d want 0", bad); end
    Active = 1'b1;
    @(negedge Clk);
    tests_run++;
    if (grant0 !== 1'b1) begin tests_failed++; $display("FAIL active_grant: got %b want 1", grant0); end
    Req0 = 1'b0;
    @(negedge Clk);
    Active = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    tests_run++;
    if (done0 !== 1'b1) begin tests_failed++; $display("FAIL inactive_done: got %b want 1", done0); end
    Req1 = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (grant0 || grant1) bad++;
    end
    tests_run++;
    if ({bad[3:0], busy} !== 5'd0) begin tests_failed++; $display("FAIL inactive_regrant: got %0d busy %b want 0", bad, busy); end
    Req1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [29:0] all_out;
    Active = 1'b1;
    do_reset();
    Req1 = 1'b1; RW1 = 1'b0; Addr1 = 4'h5;
    @(negedge Clk);
    tests_run++;
    if (grant1 !== 1'b1) begin tests_failed++; $display("FAIL mid_grant1: got %b want 1", grant1); end
    Req1 = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    all_out = {grant0, grant1, done0, done1, busy, access_mem, rw_mem, rdata, mem_addr, mem_wdata};
    tests_run++;
    if (all_out !== 30'd0) begin tests_failed++; $display("FAIL mid_reset_outputs: got %h want 0", all_out); end
    Reset = 1'b0; Req0 = 1'b1; Req1 = 1'b1;
    @(negedge Clk);
    tests_run++;
    if ({grant0, grant1, done1, access_mem} !== 4'b1001) begin
      tests_failed++; $display("FAIL mid_tie_after_reset: got %b want 1001", {grant0, grant1, done1, access_mem});
    end
    Req0 = 1'b0; Req1 = 1'b0;
  endtask

  task automatic test_latency();
    int acc_c [2];
    int done_c [2];
    int acc_n [2];
    int lat [2];
    logic [7:0] rd [2];
    logic [7:0] want;
    lat[0] = 1; lat[1] = 15;
    for (int k = 0; k < 2; k++) begin acc_c[k] = -100; done_c[k] = -1; acc_n[k] = 0; rd[k] = 8'h00; end
    Active = 1'b1; Req0 = 1'b1; RW0 = 1'b0; Addr0 = 4'h0;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      if (i == 0) Req0 = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (acc_l[k]) begin acc_n[k]++; acc_c[k] = cyc_n; end
        if (d0_l[k]) begin done_c[k] = cyc_n; rd[k] = rdata_l[k]; end
      end
    end
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (acc_n[k] !== 1) begin tests_failed++; $display("FAIL lat%0d_access_count: got %0d want 1", lat[k], acc_n[k]); end
      tests_run++;
      if (done_c[k] - acc_c[k] !== lat[k] + 1) begin
        tests_failed++; $display("FAIL lat%0d_done_delay: got %0d want %0d", lat[k], done_c[k] - acc_c[k], lat[k] + 1);
      end
      want = 8'(acc_c[k] + lat[k]);
      tests_run++;
      if (rd[k] !== want) begin tests_failed++; $display("FAIL lat%0d_rdata: got %h want %h", lat[k], rd[k], want); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_active();
    test_reset_mid();
    test_latency();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
